div32_iter: RTL and testbench



---
 rtl/div32_iter.sv | 76 +++++++
 tb/tb_div32_iter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/div32_iter.sv
// div32_iter: iterative 32-bit signed restoring divider, one trial subtraction per clock through a carry-lookahead adder
module div32_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_b, r_q;
    logic [32:0] r_rem;
    logic        r_sign, r_zero;
    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_rs, w_nb, w_x, w_diff;
    logic [33:0] w_g, w_p;
    logic        w_cout;
    assign w_abs_a = data_operandA[31] ? 32'd0 - data_operandA : data_operandA;
    assign w_abs_b = data_operandB[31] ? 32'd0 - data_operandB : data_operandB;
    assign w_rs    = {r_rem[31:0], r_q[31]};
    assign w_nb    = ~{1'b0, r_b};
    assign w_x     = w_rs ^ w_nb;
    // Kogge-Stone prefix carries; bit 0 of the extended vector is the carry-in of 1
    always_comb begin
        w_g = {w_rs & w_nb, 1'b1};
        w_p = {w_x, 1'b0};
        for (int s = 1; s < 34; s = s * 2) begin
            w_g = w_g | (w_p & (w_g << s));
            w_p = w_p & (w_p << s);
        end
    end
    assign w_diff = w_x ^ w_g[32:0];
    assign w_cout = w_g[33];
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= 6'd0;
            r_b            <= 32'd0;
            r_q            <= 32'd0;
            r_rem          <= 33'd0;
            r_sign         <= 1'b0;
            r_zero         <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (r_state == FIX) begin
                data_result    <= r_zero ? 32'd0 : (r_sign ? 32'd0 - r_q : r_q);
                data_exception <= r_zero;
                data_resultRDY <= 1'b1;
                r_state        <= IDLE;
            end
            if (r_state == RUN) begin
                r_rem   <= w_cout ? w_diff : w_rs;
                r_q     <= {r_q[30:0], w_cout};
                r_cnt   <= r_cnt + 6'd1;
                r_state <= (r_cnt == 6'd31) ? FIX : RUN;
            end
            // a new start overrides any step in flight; a finishing FIX still strobes
            if (ctrl_DIV) begin
                r_b     <= w_abs_b;
                r_q     <= w_abs_a;
                r_rem   <= 33'd0;
                r_sign  <= data_operandA[31] ^ data_operandB[31];
                r_zero  <= (data_operandB == 32'd0);
                r_cnt   <= 6'd0;
                r_state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_div32_iter.sv
// tb_div32_iter: randomized scoreboard bench for div32_iter against a 64-bit arithmetic reference
module tb_div32_iter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0, data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    div32_iter dut (
        .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    logic        rst_q = 1'b1;
    int          checks = 0, failures = 0;
    logic [31:0] last_res = 32'd0;
    logic        last_exc = 1'b0;

    function automatic exp_t ref_div(logic [31:0] a, logic [31:0] b, int due);
        exp_t   e;
        longint sa, sq;
        sa = longint'($signed(a));
        e.due = due;
        if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else begin
            sq = sa / longint'($signed(b));
            e.res = sq[31:0];
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // model: sees the same edges as the DUT and predicts what each start produces
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            rst_q = reset;
            if (reset) sb.delete();
            else if (ctrl_DIV) begin
                if (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
                sb.push_back(ref_div(data_operandA, data_operandB, cyc + 33));
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // monitor: samples on the falling edge, pops on each strobe
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (rst_q) begin
                check("reset_result", data_result, 32'd0);
                check("reset_exc", {31'd0, data_exception}, 32'd0);
                check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
                last_res = 32'd0;
                last_exc = 1'b0;
            end else if (data_resultRDY) begin
                if (sb.size() == 0) check("spurious_strobe", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("latency_edge", cyc, e.due);
                    check("result", data_result, e.res);
                    check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                    last_res = e.res;
                    last_exc = e.exc;
                end
            end else begin
                check("hold_result", data_result, last_res);
                check("hold_exc", {31'd0, data_exception}, {31'd0, last_exc});
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    check("missing_strobe", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(logic [31:0] a, logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return $urandom_range(0, 200) - 100;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] dir_a[8] = '{32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C, 32'd7, 32'd5, 32'd9, 32'h80000000, 32'h80000000};
    logic [31:0] dir_b[8] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFF9C, 32'd0, 32'd3, 32'hFFFFFFFF, 32'd1};

    initial begin
        idle(3);
        reset = 1'b0;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            issue(dir_a[i], dir_b[i]);
            idle(36);
        end
        // back-to-back: each new start lands on the finishing edge
        issue(32'd1000, 32'd10);
        for (int i = 0; i < 4; i++) begin
            idle(31);
            issue(pick(), pick());
        end
        idle(36);
        // restart at edge 10 of a running divide
        issue(32'd100, 32'd7);
        idle(8);
        issue(32'd50, 32'd5);
        idle(40);
        // reset in the middle of an operation
        issue(32'd100, 32'd7);
        idle(14);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(3);
        issue(32'd81, 32'd9);
        idle(36);
        for (int i = 0; i < 40; i++) begin
            issue(pick(), pick());
            idle($urandom_range(0, 45));
        end
        idle(40);
        if (sb.size() != 0) check("drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
